// File: rtl/trng_crngt.sv
// Continuous repetition test between the TRNG bit collector and the EHR.
// The first word after reset becomes the reference; each following word must differ from the previous one.
module trng_crngt #(
   parameter bit ERR_HALT = 1'b1
) (
   input  logic        rng_clk,
   input  logic        rst_n,
   input  logic        rst_trng_logic,
   input  logic        crngt_en,
   input  logic        crngt_bypass,
   input  logic        collector_valid,
   input  logic [15:0] collector_crngt_data,
   output logic        crngt_collector_rd,
   input  logic        ehr_ready,
   output logic        crngt_ehr_valid,
   output logic [15:0] crngt_ehr_data,
   output logic        crngt_err,
   output logic [7:0]  crngt_word_cnt
);

   typedef enum logic [1:0] {IDLE, LOAD_REF, RUN, ERR} state_e;

   state_e      state_q;
   logic [15:0] ref_q;
   logic [15:0] data_q;
   logic        ref_loaded_q;
   logic        bypass_q;
   logic        vld_q;
   logic        err_q;
   logic [7:0]  cnt_q;

   logic stall, rd, xfer, in_run, repeat_hit, fwd;

   // A read in RUN is allowed only when the output register is free or drains this cycle.
   assign stall      = vld_q & ~ehr_ready;
   assign in_run     = (state_q == RUN);
   assign rd         = ~rst_trng_logic & collector_valid &
                       ((state_q == LOAD_REF) | (in_run & ~stall));
   assign xfer       = vld_q & ehr_ready;
   assign repeat_hit = rd & in_run & ~bypass_q & (collector_crngt_data == ref_q);
   assign fwd        = rd & in_run & ~repeat_hit;

   always_ff @(posedge rng_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ref_q        <= '0;
         data_q       <= '0;
         ref_loaded_q <= 1'b0;
         bypass_q     <= 1'b0;
         vld_q        <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else if (rst_trng_logic) begin
         state_q      <= IDLE;
         ref_q        <= '0;
         data_q       <= '0;
         ref_loaded_q <= 1'b0;
         bypass_q     <= 1'b0;
         vld_q        <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         if (fwd) begin
            data_q       <= collector_crngt_data;
            ref_q        <= collector_crngt_data;
            ref_loaded_q <= 1'b1;
         end
         if (fwd)       vld_q <= 1'b1;
         else if (xfer) vld_q <= 1'b0;
         if (xfer && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
         if (repeat_hit) err_q <= 1'b1;

         case (state_q)
            IDLE: begin
               // Bypass is sampled only here so a mid-stream change cannot split a run.
               if (crngt_en) begin
                  bypass_q <= crngt_bypass;
                  state_q  <= (crngt_bypass || ref_loaded_q) ? RUN : LOAD_REF;
               end
            end
            LOAD_REF: begin
               if (rd) begin
                  ref_q        <= collector_crngt_data;
                  ref_loaded_q <= 1'b1;
               end
               if (!crngt_en) state_q <= IDLE;
               else if (rd)   state_q <= RUN;
            end
            RUN: begin
               if (repeat_hit && ERR_HALT) state_q <= ERR;
               else if (!crngt_en)         state_q <= IDLE;
            end
            default: ;
         endcase
      end
   end

   assign crngt_collector_rd = rd;
   assign crngt_ehr_valid    = vld_q;
   assign crngt_ehr_data     = data_q;
   assign crngt_err          = err_q;
   assign crngt_word_cnt     = cnt_q;

endmodule

// File: tb/tb_trng_crngt.sv
// Bench for trng_crngt: a word-list model predicts which collector words are forwarded,
// dropped as reference or flagged as repeats; two instances cover both ERR_HALT settings.
module tb_trng_crngt;
   logic rng_clk = 1'b0;
   always #5 rng_clk = ~rng_clk;

   logic        rst_n, rst_trng_logic, crngt_en, crngt_bypass, collector_valid, ehr_ready;
   logic [15:0] collector_crngt_data;
   logic        rd_h, vld_h, err_h, rd_c, vld_c, err_c;
   logic [15:0] dat_h, dat_c;
   logic [7:0]  cnt_h, cnt_c;

   trng_crngt #(.ERR_HALT(1'b1)) u_halt (
      .rng_clk(rng_clk), .rst_n(rst_n), .rst_trng_logic(rst_trng_logic), .crngt_en(crngt_en),
      .crngt_bypass(crngt_bypass), .collector_valid(collector_valid),
      .collector_crngt_data(collector_crngt_data), .crngt_collector_rd(rd_h), .ehr_ready(ehr_ready),
      .crngt_ehr_valid(vld_h), .crngt_ehr_data(dat_h), .crngt_err(err_h), .crngt_word_cnt(cnt_h));

   trng_crngt #(.ERR_HALT(1'b0)) u_cont (
      .rng_clk(rng_clk), .rst_n(rst_n), .rst_trng_logic(rst_trng_logic), .crngt_en(crngt_en),
      .crngt_bypass(crngt_bypass), .collector_valid(collector_valid),
      .collector_crngt_data(collector_crngt_data), .crngt_collector_rd(rd_c), .ehr_ready(ehr_ready),
      .crngt_ehr_valid(vld_c), .crngt_ehr_data(dat_c), .crngt_err(err_c), .crngt_word_cnt(cnt_c));

   // sel_cont picks which instance the collector/EHR model talks to
   bit          sel_cont;
   logic        rd, vld, err;
   logic [15:0] dat;
   logic [7:0]  cnt;
   assign rd  = sel_cont ? rd_c  : rd_h;
   assign vld = sel_cont ? vld_c : vld_h;
   assign dat = sel_cont ? dat_c : dat_h;
   assign err = sel_cont ? err_c : err_h;
   assign cnt = sel_cont ? cnt_c : cnt_h;

   int checks = 0, passed = 0;
   int xfers;
   bit rand_ready, sb_off, pend_lat, pend_err, model_err;
   logic [15:0] wq[$];
   logic [15:0] coll_q[$];
   bit          fwd_q[$];
   bit          rep_q[$];
   logic [15:0] exp_q[$];

   // Sequence-level model: what happens to each word, given only the rules of the test.
   task automatic model(input bit byp, input bit halt);
      bit loaded = 0, stop = 0;
      logic [15:0] r = '0;
      coll_q = wq; fwd_q.delete(); rep_q.delete(); exp_q.delete(); model_err = 0;
      foreach (wq[i]) begin
         if (stop) begin fwd_q.push_back(0); rep_q.push_back(0); end
         else if (!byp && !loaded) begin loaded = 1; r = wq[i]; fwd_q.push_back(0); rep_q.push_back(0); end
         else if (!byp && wq[i] == r) begin
            fwd_q.push_back(0); rep_q.push_back(1); model_err = 1;
            if (halt) stop = 1;
         end else begin
            r = wq[i]; fwd_q.push_back(1); rep_q.push_back(0); exp_q.push_back(wq[i]);
         end
      end
      wq.delete();
   endtask

   task automatic drive_coll();
      collector_valid      = (coll_q.size() > 0);
      collector_crngt_data = (coll_q.size() > 0) ? coll_q[0] : 16'h0;
   endtask

   task automatic tick();
      @(negedge rng_clk);
      if (pend_lat) begin
         checks++;
         if (vld !== 1'b1) $display("FAIL latency: valid=%b required 1 one cycle after read", vld);
         else passed++;
      end
      if (pend_err) begin
         checks++;
         if (err !== 1'b1) $display("FAIL repeat_err_edge: err=%b required 1", err);
         else passed++;
      end
      pend_lat = 0; pend_err = 0;
      if (!sb_off && vld === 1'b1 && ehr_ready) begin
         xfers++;
         checks++;
         if (exp_q.size() == 0) $display("FAIL xfer_data: got %h required no transfer", dat);
         else if (dat !== exp_q[0]) $display("FAIL xfer_data: got %h required %h", dat, exp_q[0]);
         else passed++;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (rd === 1'b1 && coll_q.size() > 0) begin
         pend_lat = fwd_q.pop_front();
         pend_err = rep_q.pop_front();
         void'(coll_q.pop_front());
      end
      @(posedge rng_clk); #1;
      drive_coll();
      if (rand_ready) ehr_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset(input bit cont);
      sel_cont = cont; rand_ready = 0; sb_off = 0; pend_lat = 0; pend_err = 0; xfers = 0;
      rst_n = 0; rst_trng_logic = 0; crngt_en = 0; crngt_bypass = 0; ehr_ready = 1;
      coll_q.delete(); exp_q.delete(); fwd_q.delete(); rep_q.delete(); drive_coll();
      repeat (2) @(posedge rng_clk);
      #1 rst_n = 1;
   endtask

   task automatic run_until_drained(input int limit, input string name);
      int n = 0;
      while ((coll_q.size() > 0 || exp_q.size() > 0 || vld === 1'b1) && n < limit) begin tick(); n++; end
      if (n == limit) begin
         checks++;
         $display("FAIL %s_timeout: %0d words left, %0d outputs left", name, coll_q.size(), exp_q.size());
      end
      repeat (2) tick();
   endtask

   task automatic test_reset();
      do_reset(0);
      wq.push_back(16'hBEEF); model(0, 1); drive_coll();
      #2;
      checks++;
      if ({vld_h, dat_h, err_h, cnt_h, rd_h} !== '0 || {vld_c, dat_c, err_c, cnt_c, rd_c} !== '0)
         $display("FAIL reset_state: halt=%b/%h/%b/%h/%b cont=%b/%h/%b/%h/%b required all 0",
                  vld_h, dat_h, err_h, cnt_h, rd_h, vld_c, dat_c, err_c, cnt_c, rd_c);
      else passed++;
   endtask

   task automatic test_basic();
      do_reset(0);
      wq = '{16'h1234, 16'hABCD, 16'h5555}; model(0, 1); drive_coll();
      crngt_en = 1;
      run_until_drained(30, "basic");
      checks++;
      if (xfers !== 2 || cnt !== 8'd2 || err !== 1'b0)
         $display("FAIL basic: xfers=%0d cnt=%0d err=%b required 2/2/0", xfers, cnt, err);
      else passed++;
   endtask

   task automatic test_halt();
      int bad = 0;
      do_reset(0);
      wq = '{16'h00FF, 16'h00FF, 16'h1111}; model(0, 1); drive_coll();
      crngt_en = 1;
      repeat (8) tick();
      checks++;
      if (err !== 1'b1 || xfers !== 0)
         $display("FAIL halt_err: err=%b xfers=%0d required 1/0", err, xfers);
      else passed++;
      repeat (6) begin
         #1 if (collector_valid !== 1'b1 || rd !== 1'b0 || vld !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad != 0) $display("FAIL halt_no_read: %0d cycles with a read or output, required 0", bad);
      else passed++;
   endtask

   task automatic test_cont();
      do_reset(1);
      wq = '{16'h00FF, 16'h00FF, 16'h0100}; model(0, 0); drive_coll();
      crngt_en = 1;
      run_until_drained(30, "cont");
      checks++;
      if (err !== 1'b1 || xfers !== 1 || cnt !== 8'd1)
         $display("FAIL cont: err=%b xfers=%0d cnt=%0d required 1/1/1", err, xfers, cnt);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [15:0] w0, w1, w2, held;
      int n = 0, bad = 0;
      do_reset(0);
      w0 = 16'($urandom); w1 = w0 + 16'd1 + 16'($urandom_range(0, 99)); w2 = w1 + 16'd1 + 16'($urandom_range(0, 99));
      wq = '{w0, w1, w2}; model(0, 1); drive_coll();
      ehr_ready = 0; crngt_en = 1;
      while (vld !== 1'b1 && n < 10) begin tick(); n++; end
      held = dat;
      repeat (4) begin
         #1 if (rd !== 1'b0 || vld !== 1'b1 || dat !== held || collector_valid !== 1'b1) bad++;
         tick();
      end
      checks++;
      if (bad != 0 || held !== w1) $display("FAIL bp_hold: %0d bad cycles, held=%h required 0 and %h", bad, held, w1);
      else passed++;
      ehr_ready = 1; #1;
      checks++;
      if (rd !== 1'b1 || vld !== 1'b1) $display("FAIL bp_same_cycle: rd=%b valid=%b required 1/1", rd, vld);
      else passed++;
      tick();
      checks++;
      if (vld !== 1'b1 || dat !== w2) $display("FAIL bp_reload: valid=%b data=%h required 1/%h", vld, dat, w2);
      else passed++;
      run_until_drained(20, "bp");
   endtask

   task automatic test_bypass();
      do_reset(0);
      wq = '{16'hAAAA, 16'hAAAA}; model(1, 1); drive_coll();
      crngt_bypass = 1; crngt_en = 1;
      run_until_drained(30, "bypass");
      checks++;
      if (err !== 1'b0 || xfers !== 2 || cnt !== 8'd2)
         $display("FAIL bypass: err=%b xfers=%0d cnt=%0d required 0/2/2", err, xfers, cnt);
      else passed++;
   endtask

   task automatic test_random();
      logic [15:0] prev = '0;
      for (int t = 0; t < 2; t++) begin
         do_reset(t == 0);
         for (int i = 0; i < 40; i++) begin
            prev = (i > 0 && $urandom_range(0, 3) == 0) ? prev : 16'($urandom);
            wq.push_back(prev);
         end
         model(0, t != 0); drive_coll();
         rand_ready = 1; crngt_en = 1;
         if (t == 0) run_until_drained(600, "random");
         else repeat (150) tick();
         rand_ready = 0; ehr_ready = 1;
         repeat (3) tick();
         checks++;
         if (cnt !== 8'(xfers) || err !== model_err || exp_q.size() != 0)
            $display("FAIL random%0d: cnt=%0d err=%b left=%0d required %0d/%b/0",
                     t, cnt, err, exp_q.size(), xfers, model_err);
         else passed++;
      end
   endtask

   task automatic test_saturate();
      do_reset(0);
      for (int i = 0; i < 300; i++) wq.push_back(16'(i + 1));
      model(1, 1); drive_coll();
      crngt_bypass = 1; crngt_en = 1;
      run_until_drained(400, "sat");
      checks++;
      if (cnt !== 8'd255 || xfers !== 300)
         $display("FAIL saturate: cnt=%0d xfers=%0d required 255/300", cnt, xfers);
      else passed++;
   endtask

   task automatic test_sync_reset();
      int n = 0;
      do_reset(0);
      wq = '{16'h0011, 16'h0022, 16'h0022, 16'h0033}; model(0, 1); drive_coll();
      crngt_en = 1;
      repeat (8) tick();
      checks++;
      if (err !== 1'b1 || cnt !== 8'd1) $display("FAIL pre_sync: err=%b cnt=%0d required 1/1", err, cnt);
      else passed++;
      rst_trng_logic = 1; #1;
      checks++;
      if (rd !== 1'b0 || collector_valid !== 1'b1) $display("FAIL sync_rd: rd=%b required 0", rd);
      else passed++;
      tick();
      rst_trng_logic = 0;
      checks++;
      if ({vld, dat, err, cnt} !== '0) $display("FAIL sync_clear: %b/%h/%b/%h required all 0", vld, dat, err, cnt);
      else passed++;
      // back to IDLE with no reference: the next word must be swallowed as the new reference
      wq = '{16'h0033, 16'h0044}; model(0, 1); drive_coll(); xfers = 0;
      run_until_drained(20, "sync_reload");
      checks++;
      if (xfers !== 1 || cnt !== 8'd1) $display("FAIL sync_reload: xfers=%0d cnt=%0d required 1/1", xfers, cnt);
      else passed++;
      // pending transfer in the same cycle as the synchronous clear is cancelled
      do_reset(0);
      wq = '{16'h0001, 16'h0002, 16'h0003}; model(0, 1); drive_coll();
      ehr_ready = 0; crngt_en = 1;
      while (vld !== 1'b1 && n < 10) begin tick(); n++; end
      sb_off = 1; ehr_ready = 1; rst_trng_logic = 1;
      tick();
      rst_trng_logic = 0;
      checks++;
      if (vld !== 1'b0 || cnt !== 8'd0 || n == 10) $display("FAIL sync_xfer: valid=%b cnt=%0d required 0/0", vld, cnt);
      else passed++;
      sb_off = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_halt();
      test_cont();
      test_backpressure();
      test_bypass();
      test_random();
      test_saturate();
      test_sync_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/trng_crngt.md
TRNG_CRNGT -- requirements
Module: trng_crngt

Interface
REQ-001 The parameter ERR_HALT SHALL default to 1: 1 = halt after a repeat error; 0 = drop the repeated word and continue.
REQ-002 rng_clk SHALL be an input, 1 bit: the TRNG clock; all state SHALL update on its rising edge.
REQ-003 rst_n SHALL be an input, 1 bit: the reset, asynchronous, active-low.
REQ-004 rst_trng_logic SHALL be an input, 1 bit: a synchronous clear, active-high.
REQ-005 crngt_en SHALL be an input, 1 bit: when 1, the block consumes collector words.
REQ-006 crngt_bypass SHALL be an input, 1 bit: when 1, the repetition test and the reference discard are skipped.
REQ-007 collector_valid SHALL be an input, 1 bit: the collector holds a full 16-bit word.
REQ-008 collector_crngt_data SHALL be an input, 16 bits: the collector word.
REQ-009 crngt_collector_rd SHALL be an output, 1 bit: a read strobe that clears the collector.
REQ-010 ehr_ready SHALL be an input, 1 bit: the downstream EHR accepts a word.
REQ-011 crngt_ehr_valid SHALL be an output, 1 bit: the output word is valid.
REQ-012 crngt_ehr_data SHALL be an output, 16 bits: the output word.
REQ-013 crngt_err SHALL be an output, 1 bit: a sticky repetition-failure flag.
REQ-014 crngt_word_cnt SHALL be an output, 8 bits: a saturating count of words forwarded.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LOAD_REF, RUN and ERR.
REQ-016 IDLE SHALL transition to LOAD_REF when crngt_en=1 and crngt_bypass=0, and to RUN when crngt_en=1 and crngt_bypass=1.
REQ-017 LOAD_REF SHALL, when collector_valid=1, assert crngt_collector_rd, latch the word into ref_q, not forward it, and go to RUN.
REQ-018 crngt_collector_rd SHALL be combinational and equal (LOAD_REF & collector_valid) | (RUN & collector_valid & !(crngt_ehr_valid & !ehr_ready)).
REQ-019 crngt_collector_rd SHALL be asserted for exactly one cycle per word, because the collector drops valid on the next edge.
REQ-020 In RUN, a read SHALL sample collector_crngt_data in the same cycle as the strobe.
REQ-021 In RUN, a read word that differs from ref_q (or any read word when crngt_bypass=1) SHALL load the output register and update ref_q.
REQ-022 In RUN, a read word equal to ref_q with crngt_bypass=0 SHALL be dropped and SHALL set crngt_err to 1 on the next edge.
REQ-023 After a repeat with ERR_HALT=1, the FSM SHALL go to ERR; with ERR_HALT=0 it SHALL stay in RUN with ref_q unchanged.
REQ-024 ERR SHALL issue no reads and SHALL exit only on rst_trng_logic or rst_n.
REQ-025 Output handshake: a word SHALL transfer when crngt_ehr_valid=1 and ehr_ready=1.
REQ-026 crngt_ehr_valid and crngt_ehr_data SHALL be held stable until the transfer.
REQ-027 A new word SHALL load into the output register in the same cycle as a transfer, giving back-to-back throughput.
REQ-028 Latency SHALL be 1 cycle: a read strobe in cycle N SHALL give crngt_ehr_valid=1 in cycle N+1.
REQ-029 crngt_word_cnt SHALL increment on each transfer and saturate at 255.
REQ-030 crngt_en falling to 0 SHALL stop new reads and SHALL return the FSM to IDLE.
REQ-031 After crngt_en falls, a pending output word SHALL remain valid until transferred, and ref_q SHALL be kept.
REQ-032 From IDLE, re-enable SHALL go directly to RUN when ref_q has already been loaded since the last reset; otherwise it SHALL go to LOAD_REF.
REQ-033 A crngt_bypass change SHALL take effect only at the IDLE exit.

Reset
REQ-034 On rst_n=0, asynchronously: state=IDLE, ref_q=0, ref_loaded=0, crngt_ehr_valid=0, crngt_ehr_data=0, crngt_err=0, crngt_word_cnt=0.
REQ-035 rst_trng_logic=1 SHALL apply the same values synchronously, with priority over all other events in that cycle, including a pending transfer and a simultaneous repeat.
REQ-036 crngt_collector_rd SHALL be 0 in any cycle in which rst_trng_logic=1.

Verification
REQ-037 The bench SHALL check: crngt_en=1, bypass=0, words 0x1234, 0xABCD, 0x5555, ehr_ready=1 -> 0x1234 discarded as reference; 0xABCD then 0x5555 output; crngt_word_cnt=2; crngt_err=0.
REQ-038 The bench SHALL check: reference 0x00FF, then 0x00FF with ERR_HALT=1 -> crngt_err=1 on the next edge, no output, FSM in ERR, crngt_collector_rd=0 thereafter while collector_valid=1.
REQ-039 The bench SHALL check: same stimulus with ERR_HALT=0, then 0x0100 -> crngt_err=1 sticky; 0x0100 forwarded; crngt_word_cnt=1.
REQ-040 The bench SHALL check: ehr_ready=0 with an output pending and collector_valid=1 -> no read until ehr_ready=1; then a transfer and a new load in the same cycle.
REQ-041 The bench SHALL check: bypass=1 with repeated words 0xAAAA, 0xAAAA -> both forwarded; crngt_err=0; crngt_word_cnt=2.
REQ-042 The bench SHALL check: 300 transfers -> crngt_word_cnt=255.
REQ-043 The bench SHALL check: rst_trng_logic pulsed in ERR with crngt_ehr_valid=1 -> all outputs 0 on the next cycle and state IDLE.
